mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter_fetch_fairness.sv | 40 ++++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Pure declarations: no latency or flow control of its own.
package mem_arb_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      INSTR = 2'd2
   } state_e;

   typedef struct packed {
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and memory ports of the arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [BE_W-1:0]   d_be;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              m_req;
   logic              m_we;
   logic [BE_W-1:0]   m_be;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_ack;
   logic [DATA_W-1:0] m_rdata;

   logic              err;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_req, m_we, m_be, m_addr, m_wdata, err
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_req, m_we, m_be, m_addr, m_wdata, err
   );
endinterface

// File: rtl/mem_arbiter_fetch_fairness.sv
// Picks fetch or data: data wins unless fetch has already lost LOSS_MAX times in a row.
// Zero-latency select; the loss count updates on the grant edge; no backpressure.
module fetch_fairness #(
   parameter int LOSS_MAX = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_en,
   input  logic i_req,
   input  logic d_req,
   output logic i_win,
   output logic d_win
);
   localparam int LOSS_W = (LOSS_MAX < 1) ? 1 : $clog2(LOSS_MAX + 1);

   logic [LOSS_W-1:0] loss_q, loss_d;
   logic              fetch_due;

   always_comb begin
      fetch_due = (loss_q == LOSS_W'(LOSS_MAX));
      i_win     = arb_en && i_req && (!d_req || fetch_due);
      d_win     = arb_en && d_req && !(i_req && fetch_due);

      loss_d = loss_q;
      if (i_win) begin
         loss_d = '0;
      end else if (d_win && i_req) begin
         // fetch_due is false here, so the increment cannot pass LOSS_MAX
         loss_d = loss_q + LOSS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         loss_q <= '0;
      end else begin
         loss_q <= loss_d;
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data; data has priority with bounded fetch starvation.
// Grant to rvalid is 2 cycles minimum, TIMEOUT+1 maximum; requesters stall by holding req until gnt.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT  = 64,
   parameter int LOSS_MAX = 3
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   mem_req_t          req_q, req_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_rvalid_q, i_rvalid_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic              err_q, err_d;
   logic              arb_en, i_win, d_win, timeout;

   assign arb_en  = rst && (state_q == IDLE);
   assign timeout = (wait_q == WAIT_W'(TIMEOUT - 1));

   fetch_fairness #(
      .LOSS_MAX (LOSS_MAX)
   ) u_fairness (
      .clk    (clk),
      .rst    (rst),
      .arb_en (arb_en),
      .i_req  (bus.i_req),
      .d_req  (bus.d_req),
      .i_win  (i_win),
      .d_win  (d_win)
   );

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      wait_d     = wait_q;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      i_rvalid_d = 1'b0;
      d_rvalid_d = 1'b0;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            if (d_win) begin
               req_d.we    = bus.d_we;
               req_d.be    = bus.d_be;
               req_d.addr  = bus.d_addr;
               req_d.wdata = bus.d_wdata;
               wait_d      = '0;
               state_d     = DATA;
            end else if (i_win) begin
               req_d.we    = 1'b0;
               req_d.be    = '1;
               req_d.addr  = bus.i_addr;
               req_d.wdata = '0;
               wait_d      = '0;
               state_d     = INSTR;
            end
         end
         DATA, INSTR: begin
            // An ack in the final allowed cycle beats the timeout.
            if (bus.m_ack) begin
               state_d = IDLE;
               if (state_q == INSTR) begin
                  i_rvalid_d = 1'b1;
                  i_rdata_d  = bus.m_rdata;
               end else begin
                  d_rvalid_d = 1'b1;
                  if (!req_q.we) begin
                     d_rdata_d = bus.m_rdata;
                  end
               end
            end else if (timeout) begin
               state_d = IDLE;
               err_d   = 1'b1;
               if (state_q == INSTR) begin
                  i_rvalid_d = 1'b1;
                  i_rdata_d  = NOP_INSTR;
               end else begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = '0;
               end
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         req_q      <= '0;
         wait_q     <= '0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         wait_q     <= wait_d;
         i_rdata_q  <= i_rdata_d;
         d_rdata_q  <= d_rdata_d;
         i_rvalid_q <= i_rvalid_d;
         d_rvalid_q <= d_rvalid_d;
         err_q      <= err_d;
      end
   end

   assign bus.i_gnt    = i_win;
   assign bus.d_gnt    = d_win;
   assign bus.i_rvalid = i_rvalid_q;
   assign bus.i_rdata  = i_rdata_q;
   assign bus.d_rvalid = d_rvalid_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.m_req    = (state_q != IDLE);
   assign bus.m_we     = req_q.we;
   assign bus.m_be     = req_q.be;
   assign bus.m_addr   = req_q.addr;
   assign bus.m_wdata  = req_q.wdata;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a cycle-level reference model and a variable-latency memory.
module tb_mem_arbiter;
   localparam int TIMEOUT  = 64;
   localparam int LOSS_MAX = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   mem_arbiter_if bus ();

   mem_arbiter #(
      .TIMEOUT  (TIMEOUT),
      .LOSS_MAX (LOSS_MAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_s(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %s expected %s", name, act, exp);
      end
   endtask

   // Memory responder: ack in the ack_lat-th busy cycle (0 = never).
   int ack_lat   = 1;
   bit idle_ack  = 1'b0;
   int busy_seen = 0;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h10) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
   endfunction

   initial begin
      bus.m_ack   = 1'b0;
      bus.m_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         busy_seen   = bus.m_req ? busy_seen + 1 : 0;
         bus.m_ack   = bus.m_req ? (ack_lat > 0 && busy_seen == ack_lat) : idle_ack;
         bus.m_rdata = bus.m_req ? mem_val(bus.m_addr) : 32'hBADC_0FFE;
      end
   end

   // Event monitor used by the directed checks.
   int ignt_cnt = 0, irv_cnt = 0, drv_cnt = 0, acc_cnt = 0, run = 0, last_run = 0;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         if (bus.i_gnt)    ignt_cnt++;
         if (bus.i_rvalid) irv_cnt++;
         if (bus.d_rvalid) drv_cnt++;
      end
      if (bus.m_req) begin
         run++;
      end else if (run != 0) begin
         last_run = run;
         run      = 0;
         acc_cnt++;
      end
   end

   // Reference model: owner 0 = none, 1 = fetch, 2 = data.
   int          m_owner = 0, m_busy = 0, m_loss = 0;
   bit          m_live  = 1'b0;
   logic        e_we    = 1'b0, e_irv = 1'b0, e_drv = 1'b0, e_err = 1'b0;
   logic [3:0]  e_be    = '0;
   logic [31:0] e_addr  = '0, e_wdata = '0, e_irdata = '0, e_drdata = '0;

   initial forever begin
      bit fwin, dwin;
      @(negedge clk);
      fwin = 1'b0;
      dwin = 1'b0;
      if (rst && m_owner == 0) begin
         fwin = bus.i_req && (!bus.d_req || m_loss >= LOSS_MAX);
         dwin = bus.d_req && !fwin;
      end
      if (m_live) begin
         chk("i_gnt", 32'(bus.i_gnt), 32'(fwin));
         chk("d_gnt", 32'(bus.d_gnt), 32'(dwin));
         chk("m_req", 32'(bus.m_req), 32'(m_owner != 0));
         if (m_owner != 0) begin
            chk("m_we", 32'(bus.m_we), 32'(e_we));
            chk("m_be", 32'(bus.m_be), 32'(e_be));
            chk("m_addr", bus.m_addr, e_addr);
            if (m_owner == 2) chk("m_wdata", bus.m_wdata, e_wdata);
         end
         chk("i_rvalid", 32'(bus.i_rvalid), 32'(e_irv));
         chk("d_rvalid", 32'(bus.d_rvalid), 32'(e_drv));
         chk("i_rdata", bus.i_rdata, e_irdata);
         chk("d_rdata", bus.d_rdata, e_drdata);
         chk("err", 32'(bus.err), 32'(e_err));
      end
      if (!rst) begin
         m_live  = 1'b1;
         m_owner = 0; m_busy = 0; m_loss = 0;
         e_we = 1'b0; e_be = '0; e_addr = '0; e_wdata = '0;
         e_irv = 1'b0; e_drv = 1'b0; e_irdata = '0; e_drdata = '0; e_err = 1'b0;
      end else begin
         e_irv = 1'b0;
         e_drv = 1'b0;
         if (m_owner == 0) begin
            if (dwin) begin
               m_owner = 2; m_busy = 0;
               e_we = bus.d_we; e_be = bus.d_be; e_addr = bus.d_addr; e_wdata = bus.d_wdata;
               if (bus.i_req) m_loss = (m_loss + 1 > LOSS_MAX) ? LOSS_MAX : m_loss + 1;
            end else if (fwin) begin
               m_owner = 1; m_busy = 0; m_loss = 0;
               e_we = 1'b0; e_be = 4'hF; e_addr = bus.i_addr;
            end
         end else begin
            m_busy++;
            if (bus.m_ack) begin
               if (m_owner == 1) begin
                  e_irv = 1'b1; e_irdata = bus.m_rdata;
               end else begin
                  e_drv = 1'b1;
                  if (!e_we) e_drdata = bus.m_rdata;
               end
               m_owner = 0;
            end else if (m_busy == TIMEOUT) begin
               e_err = 1'b1;
               if (m_owner == 1) begin
                  e_irv = 1'b1; e_irdata = 32'h0000_0013;
               end else begin
                  e_drv = 1'b1; e_drdata = 32'h0;
               end
               m_owner = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input bit fetch, output int gcyc);
      bit got;
      got  = 1'b0;
      gcyc = -1;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (fetch ? bus.i_gnt : bus.d_gnt) begin
            got  = 1'b1;
            gcyc = cyc;
         end
      end
      chk(fetch ? "i_gnt_wait" : "d_gnt_wait", 32'(got), 32'd1);
      tick();
      if (fetch) bus.i_req = 1'b0;
      else       bus.d_req = 1'b0;
   endtask

   task automatic wait_rvalid(input bit fetch, output int rcyc);
      bit got;
      got  = 1'b0;
      rcyc = -1;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (fetch ? bus.i_rvalid : bus.d_rvalid) begin
            got  = 1'b1;
            rcyc = cyc;
         end
      end
      chk(fetch ? "i_rvalid_wait" : "d_rvalid_wait", 32'(got), 32'd1);
      tick();
   endtask

   initial begin : stim
      int    g, r, ic, dc, ac, irc, drc;
      string seq;

      bus.i_req = 1'b1; bus.i_addr = '0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = '0; bus.d_wdata = '0;

      // Reset with both requests pending: no grants, outputs cleared.
      repeat (3) begin
         @(negedge clk);
         chk("rst_i_gnt", 32'(bus.i_gnt), 32'd0);
         chk("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
      end
      chk("rst_m_req", 32'(bus.m_req), 32'd0);
      chk("rst_m_be", 32'(bus.m_be), 32'd0);
      chk("rst_m_addr", bus.m_addr, 32'd0);
      chk("rst_i_rdata", bus.i_rdata, 32'd0);
      chk("rst_d_rdata", bus.d_rdata, 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      tick();
      rst = 1'b1; bus.i_req = 1'b0; bus.d_req = 1'b0;
      tick();

      // Idle fetch with minimum latency.
      ack_lat = 1;
      bus.i_addr = 32'h10; bus.i_req = 1'b1;
      wait_gnt(1'b1, g);
      wait_rvalid(1'b1, r);
      chk("fetch_lat", 32'(r - g), 32'd2);
      chk("fetch_rdata", bus.i_rdata, 32'h0050_0093);

      // Load with three-cycle memory latency.
      ack_lat = 3;
      bus.d_addr = 32'h200; bus.d_we = 1'b0; bus.d_req = 1'b1;
      wait_gnt(1'b0, g);
      wait_rvalid(1'b0, r);
      chk("load_lat", 32'(r - g), 32'd4);
      chk("load_rdata", bus.d_rdata, 32'h5A5A_0200);

      // Store: memory sees the write, d_rdata keeps the previous load.
      ack_lat = 2;
      bus.d_we = 1'b1; bus.d_be = 4'b0011; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
      bus.d_req = 1'b1;
      wait_gnt(1'b0, g);
      @(negedge clk);
      chk("st_m_req", 32'(bus.m_req), 32'd1);
      chk("st_m_we", 32'(bus.m_we), 32'd1);
      chk("st_m_be", 32'(bus.m_be), 32'h3);
      chk("st_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
      wait_rvalid(1'b0, r);
      chk("st_lat", 32'(r - g), 32'd3);
      chk("st_d_rdata", bus.d_rdata, 32'h5A5A_0200);
      bus.d_we = 1'b0; bus.d_be = 4'hF;

      // Acks while idle are ignored.
      irc = irv_cnt; drc = drv_cnt;
      idle_ack = 1'b1;
      repeat (4) tick();
      idle_ack = 1'b0;
      chk("idle_ack_irv", 32'(irv_cnt), 32'(irc));
      chk("idle_ack_drv", 32'(drv_cnt), 32'(drc));

      // Continuous contention: three data grants, then one fetch.
      ack_lat = 1;
      seq = "";
      bus.i_addr = 32'h20; bus.d_addr = 32'h300;
      bus.i_req = 1'b1; bus.d_req = 1'b1;
      for (int k = 0; k < 100; k++) begin
         bit was_d;
         @(negedge clk);
         was_d = bus.d_gnt;
         if (bus.d_gnt) seq = {seq, "D"};
         if (bus.i_gnt) seq = {seq, "I"};
         tick();
         if (was_d) bus.d_addr = bus.d_addr + 32'h4;
         if (seq.len() >= 8) break;
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      chk_s("fair_seq", seq, "DDDIDDDI");
      repeat (4) tick();

      // Fetch request withdrawn before a grant causes no access.
      ack_lat = 5;
      bus.d_addr = 32'h400; bus.d_req = 1'b1;
      wait_gnt(1'b0, g);
      ic = ignt_cnt; ac = acc_cnt;
      bus.i_addr = 32'h44; bus.i_req = 1'b1;
      tick(); tick();
      bus.i_req = 1'b0;
      wait_rvalid(1'b0, r);
      repeat (4) tick();
      chk("drop_no_gnt", 32'(ignt_cnt), 32'(ic));
      chk("drop_one_access", 32'(acc_cnt), 32'(ac + 1));
      chk("drop_load_rdata", bus.d_rdata, 32'h5A5A_0400);

      // Fetch timeout: NOP returned, err set and sticky.
      ack_lat = 0;
      bus.i_addr = 32'h80; bus.i_req = 1'b1;
      wait_gnt(1'b1, g);
      wait_rvalid(1'b1, r);
      chk("to_lat", 32'(r - g), 32'd65);
      chk("to_busy_cycles", 32'(last_run), 32'd64);
      chk("to_rdata", bus.i_rdata, 32'h0000_0013);
      chk("to_err", 32'(bus.err), 32'd1);
      repeat (3) tick();
      chk("to_err_sticky", 32'(bus.err), 32'd1);

      // Reset during a data access abandons it silently.
      bus.d_addr = 32'h500; bus.d_req = 1'b1;
      wait_gnt(1'b0, g);
      tick(); tick();
      dc = drv_cnt;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rstbusy_m_req", 32'(bus.m_req), 32'd0);
      chk("rstbusy_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      chk("rstbusy_err", 32'(bus.err), 32'd0);
      repeat (5) tick();
      chk("rstbusy_no_rvalid", 32'(drv_cnt), 32'(dc));

      // Ack in the last allowed busy cycle wins over the timeout.
      ack_lat = 64;
      bus.i_addr = 32'h40; bus.i_req = 1'b1;
      wait_gnt(1'b1, g);
      wait_rvalid(1'b1, r);
      chk("edge_lat", 32'(r - g), 32'd65);
      chk("edge_busy_cycles", 32'(last_run), 32'd64);
      chk("edge_rdata", bus.i_rdata, 32'h5A5A_0040);
      chk("edge_err", 32'(bus.err), 32'd0);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
